// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding, instruction opcodes and sizing helpers.
package jtag_pkg;

  localparam int JTAG_IR_W        = 5;
  localparam int RESET_TMS_CYCLES = 5;

  localparam logic [JTAG_IR_W-1:0] EXTEST = 5'h00;
  localparam logic [JTAG_IR_W-1:0] SAMPLE = 5'h01;
  localparam logic [JTAG_IR_W-1:0] BYPASS = 5'h1F;

  // The sixteen IEEE 1149.1 TAP states, plus the host-only TRST/TMS reset phase.
  typedef enum logic [4:0] {
    TLR, IDLE,
    SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR,
    RESET_SEQ
  } tap_state_t;

  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/jtag_host_shift_reg.sv
// Parallel-load IR/DR shifter: presents TDI LSB first, captures TDO MSB-in,
// and holds the last completed response.
module jtag_host_shift_reg #(
  parameter int IR_W = 5,
  parameter int DR_W = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [IR_W-1:0] load_ir,
  input  logic [DR_W-1:0] load_dr,
  input  logic            shift_ir,
  input  logic            shift_dr,
  input  logic            commit,
  input  logic            tdo,
  output logic            tdi,
  output logic [IR_W-1:0] rsp_ir,
  output logic [DR_W-1:0] rsp_dr
);

  logic [IR_W-1:0] ir_sr;
  logic [DR_W-1:0] dr_sr;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_sr  <= '0;
      dr_sr  <= '0;
      rsp_ir <= '0;
      rsp_dr <= '0;
    end else begin
      if (load) begin
        ir_sr <= load_ir;
        dr_sr <= load_dr;
      end else begin
        // After W shifts, the TDO bit sampled in shift cycle k sits at bit k.
        if (shift_ir) ir_sr <= {tdo, ir_sr[IR_W-1:1]};
        if (shift_dr) dr_sr <= {tdo, dr_sr[DR_W-1:1]};
      end
      if (commit) begin
        rsp_ir <= ir_sr;
        rsp_dr <= dr_sr;
      end
    end
  end

  assign tdi = shift_ir ? ir_sr[0] : (shift_dr ? dr_sr[0] : 1'b0);

endmodule

// File: rtl/jtag_host_ctrl.sv
// Host-side JTAG initiator: one IR scan then one DR scan per command, with an
// FSM that tracks the target TAP state edge for edge.
module jtag_host_ctrl
  import jtag_pkg::*;
#(
  parameter int  NUM_IN  = 9,
  parameter int  NUM_OUT = 5,
  parameter int  IR_W    = JTAG_IR_W,
  localparam int DR_W    = NUM_IN + NUM_OUT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IR_W-1:0] cmd_instr,
  input  logic [DR_W-1:0] cmd_data,
  output logic            rsp_valid,
  output logic [IR_W-1:0] rsp_ir,
  output logic [DR_W-1:0] rsp_dr,
  output logic            busy,
  output logic            TMS,
  output logic            TDI,
  input  logic            TDO,
  output logic            TRST
);

  localparam int CNT_W = $clog2(max_of3(IR_W, DR_W, RESET_TMS_CYCLES));

  tap_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             ir_done;
  logic             last_ir;
  logic             last_dr;
  logic             last_rst;

  assign last_ir  = (cnt == CNT_W'(IR_W - 1));
  assign last_dr  = (cnt == CNT_W'(DR_W - 1));
  assign last_rst = (cnt == CNT_W'(RESET_TMS_CYCLES - 1));

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign TRST      = (state == RESET_SEQ);

  // Select-DR is visited twice per command; ir_done tells the two visits apart.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RESET_SEQ;
      cnt       <= '0;
      ir_done   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        RESET_SEQ: begin
          if (last_rst) state <= TLR;
          else          cnt   <= cnt + 1'b1;
        end
        TLR:    state <= IDLE;
        IDLE:   if (cmd_valid) state <= SEL_DR;
        SEL_DR: state <= ir_done ? CAP_DR : SEL_IR;
        SEL_IR: state <= CAP_IR;
        CAP_IR: begin
          state <= SHIFT_IR;
          cnt   <= '0;
        end
        SHIFT_IR: begin
          if (last_ir) state <= EXIT1_IR;
          else         cnt   <= cnt + 1'b1;
        end
        EXIT1_IR: state <= UPD_IR;
        UPD_IR: begin
          state   <= SEL_DR;
          ir_done <= 1'b1;
        end
        CAP_DR: begin
          state <= SHIFT_DR;
          cnt   <= '0;
        end
        SHIFT_DR: begin
          if (last_dr) state <= EXIT1_DR;
          else         cnt   <= cnt + 1'b1;
        end
        EXIT1_DR: state <= UPD_DR;
        UPD_DR: begin
          state     <= IDLE;
          ir_done   <= 1'b0;
          rsp_valid <= 1'b1;
        end
        default: begin
          state   <= RESET_SEQ;
          cnt     <= '0;
          ir_done <= 1'b0;
        end
      endcase
    end
  end

  // TMS is the value that steers the TAP into the state this FSM enters next.
  always_comb begin
    // NOTE: default first so no path through the case leaves TMS unassigned (no latch).
    TMS = 1'b0;
    unique case (state)
      RESET_SEQ:                  TMS = 1'b1;
      IDLE:                       TMS = cmd_valid;
      SEL_DR:                     TMS = ~ir_done;
      SHIFT_IR:                   TMS = last_ir;
      SHIFT_DR:                   TMS = last_dr;
      EXIT1_IR, UPD_IR, EXIT1_DR: TMS = 1'b1;
      default:                    TMS = 1'b0;
    endcase
  end

  jtag_host_shift_reg #(
    .IR_W (IR_W),
    .DR_W (DR_W)
  ) u_shift (
    .clk      (CLK),
    .rst      (RST),
    .load     (cmd_ready & cmd_valid),
    .load_ir  (cmd_instr),
    .load_dr  (cmd_data),
    .shift_ir (state == SHIFT_IR),
    .shift_dr (state == SHIFT_DR),
    .commit   (state == UPD_DR),
    .tdo      (TDO),
    .tdi      (TDI),
    .rsp_ir   (rsp_ir),
    .rsp_dr   (rsp_dr)
  );

endmodule
